// File: rtl/pmux_ctrl_if.sv
// Configuration bus of the pin multiplexer: write strobe, address, write data
// and the registered read data returned by the block.
interface pmux_ctrl_if;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    modport master (output cfg_we, cfg_addr, cfg_wdata, input  cfg_rdata);
    modport slave  (input  cfg_we, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/pmux_ctrl.sv
// Port-A pin multiplexer: routes timer OVF / PWM or CPU GPIO data onto four pins,
// parking a pin for two cycles whenever its owner changes.
module pmux_ctrl (
    input  logic        clk,
    input  logic        rst,
    pmux_ctrl_if.slave  cfg,
    input  logic        ovf_in,
    input  logic        pwm_in,
    output logic [3:0]  porta,
    output logic        conflict
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_GPIO   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_OWNER  = 2'd3;

    typedef enum logic [1:0] {
        OWN_GPIO   = 2'b00,
        OWN_OVF    = 2'b01,
        OWN_PWM    = 2'b10,
        OWN_PARKED = 2'b11
    } owner_e;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PARK   = 1'b1
    } pin_state_e;

    logic [5:0]          r_ctrl;
    logic [3:0]          r_gpio;
    logic                r_conflict;
    logic [7:0]          r_rdata;
    logic [3:0]          r_porta;
    pin_state_e [3:0]    r_state;
    owner_e     [3:0]    r_owner;
    logic [3:0][1:0]     r_cnt;

    pin_state_e [3:0]    w_state_nxt;
    owner_e     [3:0]    w_owner_nxt;
    owner_e     [3:0]    w_desired;
    logic [3:0][1:0]     w_cnt_nxt;
    logic [3:0]          w_porta_nxt;
    logic [7:0]          w_owner_reg;
    logic [7:0]          w_rdata_nxt;
    logic [1:0]          w_ovf_sel;
    logic [1:0]          w_pwm_sel;
    logic                w_ovf_en;
    logic                w_pwm_en;
    logic                w_conf_now;
    logic                w_status_clr;

    assign w_ovf_sel  = r_ctrl[1:0];
    assign w_pwm_sel  = r_ctrl[3:2];
    assign w_ovf_en   = r_ctrl[4];
    assign w_pwm_en   = r_ctrl[5];
    assign w_conf_now = w_ovf_en && w_pwm_en && (w_ovf_sel == w_pwm_sel);
    assign w_status_clr = cfg.cfg_we && (cfg.cfg_addr == ADDR_STATUS) && cfg.cfg_wdata[0];

    // OVF is checked first, so on a select clash PWM simply owns no pin.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            w_desired[p] = OWN_GPIO;
            if (w_ovf_en && (w_ovf_sel == p[1:0])) begin
                w_desired[p] = OWN_OVF;
            end else if (w_pwm_en && (w_pwm_sel == p[1:0])) begin
                w_desired[p] = OWN_PWM;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_porta_nxt = '0;
        for (int p = 0; p < 4; p++) begin
            case (r_state[p])
                ST_STABLE: begin
                    if (w_desired[p] != r_owner[p]) begin
                        w_state_nxt[p] = ST_PARK;
                        w_cnt_nxt[p]   = 2'd2;
                    end
                end
                ST_PARK: begin
                    w_cnt_nxt[p] = r_cnt[p] - 2'd1;
                    if (r_cnt[p] == 2'd1) begin
                        w_state_nxt[p] = ST_STABLE;
                        w_owner_nxt[p] = w_desired[p];
                    end
                end
                default: begin
                    w_state_nxt[p] = ST_STABLE;
                    w_cnt_nxt[p]   = 2'd0;
                end
            endcase
            if (w_state_nxt[p] == ST_STABLE) begin
                case (w_owner_nxt[p])
                    OWN_OVF:  w_porta_nxt[p] = ovf_in;
                    OWN_PWM:  w_porta_nxt[p] = pwm_in;
                    OWN_GPIO: w_porta_nxt[p] = r_gpio[p];
                    default:  w_porta_nxt[p] = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        w_owner_reg = '0;
        for (int p = 0; p < 4; p++) begin
            w_owner_reg[2*p +: 2] = (r_state[p] == ST_PARK) ? OWN_PARKED : r_owner[p];
        end
        case (cfg.cfg_addr)
            ADDR_CTRL:   w_rdata_nxt = {2'b00, r_ctrl};
            ADDR_GPIO:   w_rdata_nxt = {4'b0000, r_gpio};
            ADDR_STATUS: w_rdata_nxt = {7'b0000000, r_conflict};
            ADDR_OWNER:  w_rdata_nxt = w_owner_reg;
            default:     w_rdata_nxt = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_gpio     <= '0;
            r_conflict <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (cfg.cfg_we && (cfg.cfg_addr == ADDR_CTRL)) begin
                r_ctrl <= cfg.cfg_wdata[5:0];
            end
            if (cfg.cfg_we && (cfg.cfg_addr == ADDR_GPIO)) begin
                r_gpio <= cfg.cfg_wdata[3:0];
            end
            if (w_conf_now) begin
                r_conflict <= 1'b1;
            end else if (w_status_clr) begin
                r_conflict <= 1'b0;
            end
            r_rdata <= w_rdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= {4{ST_STABLE}};
            r_owner <= {4{OWN_GPIO}};
            r_cnt   <= '0;
            r_porta <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_porta <= w_porta_nxt;
        end
    end

    assign porta         = r_porta;
    assign conflict      = r_conflict;
    assign cfg.cfg_rdata = r_rdata;

endmodule

// File: tb/tb_pmux_ctrl.sv
// Randomized bench for pmux_ctrl against a cycle-stamped behavioural model,
// preceded by short directed sequences for the documented switching scenarios.
module tb_pmux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ovf_in;
    logic       pwm_in;
    logic [3:0] porta;
    logic       conflict;

    pmux_ctrl_if cfg ();

    pmux_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg),
        .ovf_in   (ovf_in),
        .pwm_in   (pwm_in),
        .porta    (porta),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: registers as plain bytes, pin ownership as ints (0 GPIO, 1 OVF, 2 PWM),
    // a park is remembered as the cycle number on which it ends (-1 = no park).
    logic [7:0] m_ctrl, m_gpio, m_rdata;
    logic       m_conf;
    logic [3:0] m_porta;
    int         m_owner[4];
    int         m_park_end[4];
    int         m_cyc = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int desired(input int p);
        if (m_ctrl[4] && int'(m_ctrl[1:0]) == p) return 1;
        if (m_ctrl[5] && int'(m_ctrl[3:2]) == p) return 2;
        return 0;
    endfunction

    function automatic logic src(input int own, input int p, input logic o, input logic pw);
        if (own == 1) return o;
        if (own == 2) return pw;
        return m_gpio[p];
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            2'd0: v = m_ctrl;
            2'd1: v = m_gpio;
            2'd2: v = {7'b0, m_conf};
            default: begin
                for (int p = 0; p < 4; p++) begin
                    int code;
                    code = (m_park_end[p] >= 0) ? 3 : m_owner[p];
                    v = v | 8'(code << (2 * p));
                end
            end
        endcase
        return v;
    endfunction

    task automatic model_step(input logic r, input logic we, input logic [1:0] a,
                              input logic [7:0] d, input logic o, input logic pw);
        int         des[4];
        logic [7:0] rd;
        logic       conf_now;
        if (r) begin
            m_ctrl = 8'h00; m_gpio = 8'h00; m_conf = 1'b0; m_rdata = 8'h00; m_porta = 4'h0;
            for (int p = 0; p < 4; p++) begin
                m_owner[p]    = 0;
                m_park_end[p] = -1;
            end
        end else begin
            rd       = model_read(a);
            conf_now = m_ctrl[4] && m_ctrl[5] && (m_ctrl[1:0] == m_ctrl[3:2]);
            for (int p = 0; p < 4; p++) des[p] = desired(p);
            for (int p = 0; p < 4; p++) begin
                if (m_park_end[p] < 0) begin
                    if (des[p] != m_owner[p]) begin
                        m_park_end[p] = m_cyc + 2;
                        m_porta[p]    = 1'b0;
                    end else begin
                        m_porta[p] = src(m_owner[p], p, o, pw);
                    end
                end else if (m_cyc >= m_park_end[p]) begin
                    m_owner[p]    = des[p];
                    m_park_end[p] = -1;
                    m_porta[p]    = src(des[p], p, o, pw);
                end else begin
                    m_porta[p] = 1'b0;
                end
            end
            if (we) begin
                case (a)
                    2'd0: m_ctrl = d & 8'h3F;
                    2'd1: m_gpio = d & 8'h0F;
                    2'd2: if (d[0]) m_conf = 1'b0;
                    default: ;
                endcase
            end
            if (conf_now) m_conf = 1'b1;
            m_rdata = rd;
        end
        m_cyc++;
    endtask

    task automatic tick(input logic r, input logic we, input logic [1:0] a,
                        input logic [7:0] d, input logic o, input logic pw);
        rst           = r;
        cfg.cfg_we    = we;
        cfg.cfg_addr  = a;
        cfg.cfg_wdata = d;
        ovf_in        = o;
        pwm_in        = pw;
        @(posedge clk);
        model_step(r, we, a, d, o, pw);
        @(negedge clk);
        check("porta",    {4'b0, porta},    {4'b0, m_porta});
        check("conflict", {7'b0, conflict}, {7'b0, m_conf});
        check("rdata",    cfg.cfg_rdata,    m_rdata);
    endtask

    initial begin
        tick(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 2'd0, 8'h3F, 1'b1, 1'b1);
        check("reset_porta", {4'b0, porta}, 8'h00);
        check("reset_rdata", cfg.cfg_rdata, 8'h00);

        // GPIO write shows on the pins one cycle later; OWNER stays all-GPIO.
        tick(1'b0, 1'b1, 2'd1, 8'h0A, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
        check("gpio_porta", {4'b0, porta}, 8'h0A);
        check("gpio_owner", cfg.cfg_rdata, 8'h00);

        // OVF onto pin 2: two parked cycles, then ovf_in with one cycle latency.
        tick(1'b0, 1'b1, 2'd0, 8'h12, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
        check("ovf_mid_owner", cfg.cfg_rdata, 8'h30);
        check("ovf_mid_porta", {4'b0, porta}, 8'h0A);
        tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
        check("ovf_hi_porta", {4'b0, porta}, 8'h0E);
        tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
        check("ovf_lo_porta", {4'b0, porta}, 8'h0A);
        check("ovf_owner", cfg.cfg_rdata, 8'h10);

        // Both sources on separate pins.
        tick(1'b0, 1'b1, 2'd0, 8'h39, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 2'd3, 8'h00, 1'($urandom), 1'($urandom));
        check("both_owner", cfg.cfg_rdata, 8'h24);
        check("both_conflict", {7'b0, conflict}, 8'h00);

        // Select clash: sticky conflict, set beats clear, clears once resolved.
        tick(1'b0, 1'b1, 2'd0, 8'h35, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
        check("clash_set", {7'b0, conflict}, 8'h01);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'd3, 8'h00, 1'($urandom), 1'($urandom));
        check("clash_owner", cfg.cfg_rdata, 8'h04);
        tick(1'b0, 1'b1, 2'd2, 8'h01, 1'b0, 1'b0);
        check("clash_set_wins", {7'b0, conflict}, 8'h01);
        tick(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 2'd2, 8'h01, 1'b0, 1'b0);
        check("clash_cleared", {7'b0, conflict}, 8'h00);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);

        // Reset during a park of pin 3, with a competing write in the same cycle.
        tick(1'b0, 1'b1, 2'd0, 8'h13, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 2'd0, 8'h3F, 1'b1, 1'b1);
        check("rst_park_porta", {4'b0, porta}, 8'h00);
        tick(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        check("rst_park_ctrl", cfg.cfg_rdata, 8'h00);

        // Enable withdrawn one cycle after the request: full park, never ovf_in.
        tick(1'b0, 1'b1, 2'd0, 8'h13, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
            check("abort_pin3", {7'b0, porta[3]}, 8'h00);
        end
        check("abort_owner", cfg.cfg_rdata, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            logic       r, we;
            logic [1:0] a;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom);
            tick(r, we, a, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
